// File: rtl/twiddle_pkg.sv
// Shared definitions for the quarter-wave twiddle generator: quadrant codes,
// full-scale constant and a clog2 helper usable in parameter expressions.
package twiddle_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam real PI = 3.14159265358979323846;

  // Largest positive value of a signed word; used as +1.0 so negation never overflows.
  function automatic int fs(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_gen_quarter_wave_if.sv
// Request/response bundle of the twiddle generator: index in, (cos, sin, tag) out,
// each side with its own valid/ready pair.
interface twiddle_gen_quarter_wave_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
);

  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        k;
  logic                     inverse;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] cos_out;
  logic signed [DATA_W-1:0] sin_out;
  logic [ADDR_W-1:0]        out_k;

  modport master (
    output in_valid, k, inverse, out_ready,
    input  in_ready, out_valid, cos_out, sin_out, out_k
  );

  modport slave (
    input  in_valid, k, inverse, out_ready,
    output in_ready, out_valid, cos_out, sin_out, out_k
  );

endinterface

// File: rtl/twiddle_quarter_rom.sv
// Dual-port quarter-wave sine table, Q[i] = round(sin(2*pi*i/N) * FS) for i = 0..N/4,
// computed at elaboration; both ports have a registered read gated by ce.
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int N_POINTS = 512,
  parameter int DATA_W   = 18,
  parameter int RA_W     = 8
) (
  input  logic                     clk,
  input  logic                     ce,
  input  logic [RA_W-1:0]          addr_a,
  input  logic [RA_W-1:0]          addr_b,
  output logic signed [DATA_W-1:0] data_a,
  output logic signed [DATA_W-1:0] data_b
);

  localparam int M = N_POINTS / 4;

  logic signed [DATA_W-1:0] rom [0:M];

  // Table values are non-negative, so round-half-up is plain round-to-nearest.
  function automatic logic signed [DATA_W-1:0] quarter_sin(input int i);
    real v;
    v = $sin(2.0 * PI * real'(i) / real'(N_POINTS)) * real'(fs(DATA_W));
    return DATA_W'($rtoi(v + 0.5));
  endfunction

  generate
    for (genvar gi = 0; gi <= M; gi++) begin : g_rom
      assign rom[gi] = quarter_sin(gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ce) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen_quarter_wave.sv
// FFT twiddle generator: folds k into a quarter-wave lookup and rebuilds the
// quadrant by sign/swap. Three stages (fold, ROM read, sign) share one stall enable.
module twiddle_gen_quarter_wave
  import twiddle_pkg::*;
#(
  parameter int N_POINTS = 512,
  parameter int DATA_W   = 18
) (
  input logic                       Clk,
  input logic                       reset,
  twiddle_gen_quarter_wave_if.slave bus
);

  localparam int ADDR_W = clog2(N_POINTS);
  localparam int R_W    = ADDR_W - 2;
  localparam int RA_W   = ADDR_W - 1;
  localparam int M      = N_POINTS / 4;

  logic ce;

  logic              s1_valid_reg;
  quad_e             s1_quad_reg;
  logic              s1_inverse_reg;
  logic [ADDR_W-1:0] s1_k_reg;
  logic [RA_W-1:0]   s1_addr_lo_reg;
  logic [RA_W-1:0]   s1_addr_hi_reg;

  logic              s2_valid_reg;
  quad_e             s2_quad_reg;
  logic              s2_inverse_reg;
  logic [ADDR_W-1:0] s2_k_reg;

  logic signed [DATA_W-1:0] rom_lo;
  logic signed [DATA_W-1:0] rom_hi;
  logic signed [DATA_W-1:0] s_next;
  logic signed [DATA_W-1:0] cos_next;
  logic signed [DATA_W-1:0] sin_next;

  logic                     out_valid_reg;
  logic signed [DATA_W-1:0] cos_reg;
  logic signed [DATA_W-1:0] sin_reg;
  logic [ADDR_W-1:0]        out_k_reg;

  // The whole pipeline freezes only while a result is waiting on downstream.
  assign ce           = bus.out_ready | ~out_valid_reg;
  assign bus.in_ready = ce;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (ce) begin
      s1_valid_reg <= bus.in_valid;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // Fold: r addresses the rising quarter, M-r its mirror (r=0 reaches Q[M]).
  always_ff @(posedge Clk) begin
    if (ce) begin
      if (bus.in_valid) begin
        s1_quad_reg    <= quad_e'(bus.k[ADDR_W-1 -: 2]);
        s1_inverse_reg <= bus.inverse;
        s1_k_reg       <= bus.k;
        s1_addr_lo_reg <= RA_W'(bus.k[R_W-1:0]);
        s1_addr_hi_reg <= RA_W'(M) - RA_W'(bus.k[R_W-1:0]);
      end
      s2_quad_reg    <= s1_quad_reg;
      s2_inverse_reg <= s1_inverse_reg;
      s2_k_reg       <= s1_k_reg;
    end
  end

  twiddle_quarter_rom #(
    .N_POINTS (N_POINTS),
    .DATA_W   (DATA_W),
    .RA_W     (RA_W)
  ) u_rom (
    .clk    (Clk),
    .ce     (ce),
    .addr_a (s1_addr_lo_reg),
    .addr_b (s1_addr_hi_reg),
    .data_a (rom_lo),
    .data_b (rom_hi)
  );

  always_comb begin
    s_next   = rom_lo;
    cos_next = rom_hi;
    case (s2_quad_reg)
      Q0: begin s_next =  rom_lo; cos_next =  rom_hi; end
      Q1: begin s_next =  rom_hi; cos_next = -rom_lo; end
      Q2: begin s_next = -rom_lo; cos_next = -rom_hi; end
      Q3: begin s_next = -rom_hi; cos_next =  rom_lo; end
      default: begin s_next = rom_lo; cos_next = rom_hi; end
    endcase
    sin_next = s2_inverse_reg ? s_next : -s_next;
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      cos_reg       <= '0;
      sin_reg       <= '0;
      out_k_reg     <= '0;
    end else if (ce) begin
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        cos_reg   <= cos_next;
        sin_reg   <= sin_next;
        out_k_reg <= s2_k_reg;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.cos_out   = cos_reg;
  assign bus.sin_out   = sin_reg;
  assign bus.out_k     = out_k_reg;

endmodule

// File: tb/tb_twiddle_gen_quarter_wave.sv
// Self-checking bench for twiddle_gen_quarter_wave (N=512, DATA_W=18) against a
// real-valued cos/sin reference with a request scoreboard and stall monitor.
module tb_twiddle_gen_quarter_wave;

  localparam int N  = 512;
  localparam int DW = 18;
  localparam int AW = 9;
  localparam int FS = 131071;
  localparam real TWO_PI = 6.28318530717958647692;

  typedef struct {
    int k;
    bit inv;
  } req_t;

  typedef struct {
    int k;
    int c;
    int s;
    int cyc;
  } rsp_t;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  twiddle_gen_quarter_wave_if #(.ADDR_W(AW), .DATA_W(DW)) tw_if ();

  twiddle_gen_quarter_wave #(.N_POINTS(N), .DATA_W(DW)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (tw_if.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  req_t exp_q[$];
  rsp_t got[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_cos(input int k);
    return rnd($cos(TWO_PI * real'(k) / real'(N)) * real'(FS));
  endfunction

  function automatic int ref_sin_out(input int k, input bit inv);
    int s;
    s = rnd($sin(TWO_PI * real'(k) / real'(N)) * real'(FS));
    return inv ? s : -s;
  endfunction

  always @(posedge Clk) cyc++;

  // Monitor at negedge: inputs are stable, and a valid&ready seen here transfers next edge.
  bit prev_stall = 0;
  int prev_c, prev_s, prev_k;
  always @(negedge Clk) begin : monitor
    req_t r;
    int   c, s, ec, es;
    real  nrm;
    if (!reset) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      c = tw_if.cos_out;
      s = tw_if.sin_out;
      if (prev_stall) begin
        check_eq("hold_valid", tw_if.out_valid, 1);
        check_eq("hold_cos", c, prev_c);
        check_eq("hold_sin", s, prev_s);
        check_eq("hold_k", tw_if.out_k, prev_k);
      end
      if (tw_if.out_valid && !tw_if.out_ready)
        check_eq("in_ready_stall", tw_if.in_ready, 0);
      if (tw_if.out_valid && tw_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", tw_if.out_valid, 0);
        end else begin
          r  = exp_q.pop_front();
          ec = c - ref_cos(r.k);
          es = s - ref_sin_out(r.k, r.inv);
          check_eq("out_k_order", tw_if.out_k, r.k);
          check_eq("cos_err_le_1lsb", (ec >= -1 && ec <= 1), 1);
          check_eq("sin_err_le_1lsb", (es >= -1 && es <= 1), 1);
          nrm = real'(c) * real'(c) + real'(s) * real'(s) - real'(FS) * real'(FS);
          if (nrm < 0.0) nrm = -nrm;
          check_eq("norm_within_0p01pct", (nrm <= 1.0e-4 * real'(FS) * real'(FS)), 1);
        end
        got.push_back('{k: int'(tw_if.out_k), c: c, s: s, cyc: cyc});
      end
      if (tw_if.in_valid && tw_if.in_ready)
        exp_q.push_back('{k: int'(tw_if.k), inv: tw_if.inverse});
      prev_stall = tw_if.out_valid && !tw_if.out_ready;
      prev_c = c;
      prev_s = s;
      prev_k = int'(tw_if.out_k);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int k, input bit inv, input bit rand_rdy);
    bit acc;
    int guard;
    tw_if.in_valid = 1'b1;
    tw_if.k        = AW'(k);
    tw_if.inverse  = inv;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      if (rand_rdy) tw_if.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = tw_if.in_ready;
      tick();
      guard++;
    end
    tw_if.in_valid = 1'b0;
    if (!acc) check_eq("send_accept_timeout", acc, 1);
  endtask

  task automatic wait_got(input int n, input int budget);
    int g;
    g = 0;
    while (got.size() < n && g < budget) begin
      tick();
      g++;
    end
    check_eq("result_count", got.size(), n);
  endtask

  // One request with out_ready high; checks exact values, tag and 3-cycle latency.
  task automatic single(input int k, input bit inv, input int exp_c, input int exp_s);
    int start;
    got.delete();
    tw_if.out_ready = 1'b1;
    start = cyc;
    send(k, inv, 1'b0);
    wait_got(1, 20);
    if (got.size() >= 1) begin
      check_eq("single_cos", got[0].c, exp_c);
      check_eq("single_sin", got[0].s, exp_s);
      check_eq("single_k", got[0].k, k);
      check_eq("single_latency", got[0].cyc - start, 3);
    end
  endtask

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int start;
    int bad;
    tw_if.in_valid  = 1'b1;
    tw_if.k         = AW'($urandom);
    tw_if.inverse   = 1'b0;
    tw_if.out_ready = 1'b1;

    // Reset held with a pending request
    repeat (5) tick();
    check_eq("rst_out_valid", tw_if.out_valid, 0);
    check_eq("rst_cos", tw_if.cos_out, 0);
    check_eq("rst_sin", tw_if.sin_out, 0);
    check_eq("rst_out_k", tw_if.out_k, 0);
    tw_if.in_valid = 1'b0;
    reset = 1'b1;
    single(0, 1'b0, FS, 0);

    // Quadrant points back-to-back
    got.delete();
    start = cyc;
    send(128, 1'b0, 1'b0);
    send(256, 1'b0, 1'b0);
    send(384, 1'b0, 1'b0);
    wait_got(3, 20);
    if (got.size() >= 3) begin
      check_eq("q1_cos", got[0].c, 0);
      check_eq("q1_sin", got[0].s, -FS);
      check_eq("q2_cos", got[1].c, -FS);
      check_eq("q2_sin", got[1].s, 0);
      check_eq("q3_cos", got[2].c, 0);
      check_eq("q3_sin", got[2].s, FS);
      for (int i = 0; i < 3; i++) begin
        check_eq("quad_tag", got[i].k, 128 * (i + 1));
        check_eq("quad_cycle", got[i].cyc, start + 3 + i);
      end
    end

    // Diagonal and wrap points
    single(64, 1'b0, 92681, -92681);
    single(64, 1'b1, 92681, 92681);
    single(511, 1'b0, 131061, 1608);

    // Random backpressure over k=0..15
    got.delete();
    for (int i = 0; i < 16; i++) send(i, 1'($urandom_range(0, 1)), 1'b1);
    begin
      int g;
      g = 0;
      while (got.size() < 16 && g < 500) begin
        tw_if.out_ready = 1'($urandom_range(0, 1));
        tw_if.k         = AW'($urandom);
        tw_if.inverse   = 1'($urandom_range(0, 1));
        tick();
        g++;
      end
    end
    tw_if.out_ready = 1'b1;
    check_eq("bp_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) check_eq("bp_order", got[i].k, i);

    // Reset while three requests are in flight
    got.delete();
    send(10, 1'b0, 1'b0);
    send(200, 1'b1, 1'b0);
    send(300, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("no_stale_valid", tw_if.out_valid, 0);
      tick();
    end
    check_eq("no_stale_results", got.size(), 0);
    single(300, 1'b1, ref_cos(300), ref_sin_out(300, 1'b1));

    // Full sweep, both modes, streamed at full rate
    got.delete();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < N; k++) send(k, 1'(m), 1'b0);
    wait_got(2 * N, 100);
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].cyc != got[0].cyc + i) bad++;
      if (got[i].k != i % N) bad++;
    end
    check_eq("sweep_order_and_throughput", bad, 0);
    repeat (5) tick();
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
